// File: rtl/spm_pkg.sv
// Shared types and sizing helpers for the serial-parallel multiplier and its sequencer.
package spm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        TAIL,
        DONE
    } spm_state_t;

    localparam int SPM_SIZE_DEFAULT = 32;

    // Counter must reach 2*size-1 without wrapping.
    function automatic int spm_cnt_w(input int size);
        return $clog2(2 * size) + 1;
    endfunction

endpackage

// File: rtl/spm_seq_if.sv
// Operand-issue and product-return handshakes of the spm sequencer.
interface spm_seq_if
    import spm_pkg::*;
#(
    parameter int SIZE = SPM_SIZE_DEFAULT
) ();

    logic                in_valid;
    logic                in_ready;
    logic [SIZE-1:0]     mc;
    logic [SIZE-1:0]     mp;
    logic                out_valid;
    logic                out_ready;
    logic [2*SIZE-1:0]   prod;
    logic                busy;

    modport master (
        output in_valid, mc, mp, out_ready,
        input  in_ready, out_valid, prod, busy
    );

    modport slave (
        input  in_valid, mc, mp, out_ready,
        output in_ready, out_valid, prod, busy
    );

endinterface

// File: rtl/spm.sv
// Serial-parallel signed multiplier: parallel x, serial y (LSB first), serial product p.
// p is registered, so the product bit for the y bit applied in cycle k appears in cycle k+1.
module spm
    import spm_pkg::*;
#(
    parameter int SIZE = SPM_SIZE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] x,
    input  logic            y,
    output logic            p
);

    localparam int W = SIZE + 1;

    logic [W-1:0] acc_q, acc_d;
    logic         p_q, p_d;
    logic [W:0]   sum;

    // Partial sum kept signed; each cycle adds y*x and retires the LSB as a product bit.
    always_comb begin
        sum   = {acc_q[W-1], acc_q} + (y ? {{2{x[SIZE-1]}}, x} : '0);
        p_d   = sum[0];
        acc_d = sum[W:1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            p_q   <= 1'b0;
        end else begin
            acc_q <= acc_d;
            p_q   <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/spm_seq.sv
// Sequencer for spm: accepts an operand pair, streams the multiplier serially,
// deserialises the 2*SIZE-bit product and returns it over a valid/ready handshake.
module spm_seq
    import spm_pkg::*;
#(
    parameter int SIZE = SPM_SIZE_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    spm_seq_if.slave  bus
);

    localparam int CNT_W = spm_cnt_w(SIZE);
    localparam int IDX_W = $clog2(SIZE);
    localparam int PW    = 2 * SIZE;
    localparam logic [CNT_W-1:0] CNT_SIZE = CNT_W'(SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SIZE - 1);

    spm_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SIZE-1:0]   mc_q, mc_d;
    logic [SIZE-1:0]   mp_q, mp_d;
    logic [PW-1:0]     prod_q, prod_d;

    logic              spm_rst;
    logic [SIZE-1:0]   spm_x;
    logic              spm_y;
    logic              spm_p;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mc_d    = bus.mc;
                    mp_d    = bus.mp;
                    state_d = CLR;
                end
            end
            CLR: begin
                cnt_d   = '0;
                prod_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                // spm.p lags spm.y by one cycle, so nothing valid arrives at cnt==0.
                if (cnt_q != '0) begin
                    prod_d = {spm_p, prod_q[PW-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = TAIL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TAIL: begin
                prod_d  = {spm_p, prod_q[PW-1:1]};
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        spm_rst = ~rst_n | (state_q == CLR);
        spm_x   = (state_q == IDLE || state_q == CLR) ? '0 : mc_q;
        spm_y   = 1'b0;
        if (state_q == RUN) begin
            spm_y = (cnt_q < CNT_SIZE) ? mp_q[cnt_q[IDX_W-1:0]] : mp_q[SIZE-1];
        end
    end

    spm #(.SIZE(SIZE)) u_spm (
        .clk (clk),
        .rst (spm_rst),
        .x   (spm_x),
        .y   (spm_y),
        .p   (spm_p)
    );

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == CLR) || (state_q == RUN) || (state_q == TAIL);
    assign bus.prod      = prod_q;

endmodule
